// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
// SPI mode-0 initiator. Serialises 16-bit frames {rw, addr[6:0], data[7:0]}
// MSB first onto sclk/ncs/copi. Requests arrive on a valid/ready handshake.
// SPI timing comes from clk: each sclk half-period lasts CLK_DIV clk cycles.
//
// Optional build macro: SPI_CONTROLLER_READBACK_EN
//   When defined, adds cipo (synchronised input) and rsp_data (8-bit result
//   of the frame's last 8 bit periods, updated together with done).
//
// Parameters:
//   CLK_DIV    clk cycles per sclk half-period (>= 2)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  request valid
//   req_ready  controller idle, request accepted when valid && ready
//   req_rw     frame bit 15 (1 = write)
//   req_addr   frame bits 14:8
//   req_data   frame bits 7:0
//   done       one-cycle pulse on the first cycle after ncs rises
//   sclk       SPI clock, idles low
//   ncs        SPI chip select, active low
//   copi       SPI data out
//   cipo       SPI data in (readback build only)
//   rsp_data   captured read data (readback build only)
// ---------------------------------------------------------------------------
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
`ifdef SPI_CONTROLLER_READBACK_EN
  ,
  input  logic       cipo,
  output logic [7:0] rsp_data
`endif
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // A divider below 2 would let the peripheral synchronisers miss levels.
  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $fatal(1, "spi_controller: CLK_DIV must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [FRAME_W-1:0]   r_shift;
  logic                 r_sclk;
  logic                 r_ncs;
  logic                 r_done;
  logic                 r_ready;
  logic                 w_div_end;
  logic                 w_accept;
  logic                 w_high_end;
  logic                 w_frame_end;

  assign w_div_end   = (r_div == DIV_LAST);
  assign w_accept    = req_valid && r_ready;
  assign w_high_end  = (r_state == S_HIGH) && w_div_end;
  assign w_frame_end = (r_state == S_LOW) && (w_state_nxt == S_GAP);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. The bit counter wraps to 0 during the 16th LOW phase,
  // which marks the end of the frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)  w_state_nxt = S_LEAD;
      S_LEAD: if (w_div_end) w_state_nxt = S_HIGH;
      S_HIGH: if (w_div_end) w_state_nxt = S_LOW;
      S_LOW: begin
        if (w_div_end) begin
          w_state_nxt = (r_bit == '0) ? S_GAP : S_HIGH;
        end
      end
      S_GAP:  if (w_div_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase divider: restarts on every state change, held at 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Bit counter and transmit shift register; copi is the shift MSB, so the
  // register empties to zero after the 16th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit   <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_bit   <= '0;
      r_shift <= {req_rw, req_addr, req_data};
    end else if (w_high_end) begin
      r_bit   <= r_bit + BIT_W'(1);
      r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
    end
  end

  // Pin and handshake flops, loaded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_ncs   <= !((w_state_nxt == S_LEAD) || (w_state_nxt == S_HIGH) ||
                   (w_state_nxt == S_LOW));
      r_sclk  <= (w_state_nxt == S_HIGH);
      r_done  <= w_frame_end;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign ncs       = r_ncs;
  assign sclk      = r_sclk;
  assign copi      = r_shift[FRAME_W-1];
  assign done      = r_done;
  assign req_ready = r_ready;

`ifdef SPI_CONTROLLER_READBACK_EN
  logic [1:0] r_cipo_sync;
  logic [7:0] r_rx;
  logic [7:0] r_rsp;
  logic       w_cipo_s;

  assign w_cipo_s = r_cipo_sync[1];

  // Two-flop synchroniser for the asynchronous cipo pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cipo_sync <= '0;
    end else begin
      r_cipo_sync <= {r_cipo_sync[0], cipo};
    end
  end

  // Sample at the end of each HIGH phase of frame bits 7..0 (bit count 8..15).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx <= '0;
    end else if (w_high_end && r_bit[BIT_W-1]) begin
      r_rx <= {r_rx[6:0], w_cipo_s};
    end
  end

  // Response is published together with done and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else if (w_frame_end) begin
      r_rsp <= r_rx;
    end
  end

  assign rsp_data = r_rsp;
`endif

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

`ifdef SPI_CONTROLLER_READBACK_EN
  localparam int CD = 2;
`else
  localparam int CD = 4;
`endif
  localparam int LOW_CYC  = 33 * CD;  // cycles with ncs low
  localparam int BUSY_CYC = 34 * CD;  // cycles from acceptance to idle

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       done;
  logic       sclk;
  logic       ncs;
  logic       copi;
`ifdef SPI_CONTROLLER_READBACK_EN
  logic       cipo;
  logic [7:0] rsp_data;
`endif

  spi_controller #(.CLK_DIV(CD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .done      (done),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi)
`ifdef SPI_CONTROLLER_READBACK_EN
    ,
    .cipo      (cipo),
    .rsp_data  (rsp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level view of the controller.
  int          busy = 0;         // cycles left until idle, 0 = idle
  int          n_accept = 0;
  logic [15:0] m_frame = '0;
  logic [15:0] exp_q[$];
  logic [7:0]  m_rsp = '0;
  logic [7:0]  cur_rsp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      exp_q.delete();
      m_rsp = '0;
    end else if (busy == 0) begin
      if (req_valid) begin
        busy    = BUSY_CYC;
        m_frame = {req_rw, req_addr, req_data};
        exp_q.push_back(m_frame);
        n_accept++;
      end
    end else begin
      busy--;
    end
  end

  // Cycle-by-cycle pin expectations derived from the frame timing rules.
  always @(negedge clk) begin
    int   k;
    int   bp;
    logic e_ncs, e_sclk, e_copi, e_done, e_ready;
    if (rst_n) begin
      k       = (busy > 0) ? (BUSY_CYC - busy) : -1;
      e_ncs   = !(k >= 0 && k < LOW_CYC);
      e_sclk  = (k >= CD) && (k < LOW_CYC) && ((((k - CD) / CD) % 2) == 0);
      e_copi  = 1'b0;
      if (k >= 0 && k < LOW_CYC) begin
        bp = (k < CD) ? 0 : ((((k - CD) / CD) + 1) / 2);
        if (bp < 16) e_copi = m_frame[15 - bp];
      end
      e_done  = (k == LOW_CYC);
      e_ready = (busy == 0);
      check("ncs",   32'(ncs),       32'(e_ncs));
      check("sclk",  32'(sclk),      32'(e_sclk));
      check("copi",  32'(copi),      32'(e_copi));
      check("done",  32'(done),      32'(e_done));
      check("ready", 32'(req_ready), 32'(e_ready));
`ifdef SPI_CONTROLLER_READBACK_EN
      if (e_done) m_rsp = cur_rsp;
      check("rsp", 32'(rsp_data), 32'(m_rsp));
`endif
    end
  end

  // Wire-level frame monitor: captures copi on sclk rising edges.
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        cap_on = 1'b0;
  logic [15:0] cap = '0;
  logic [15:0] last_cap = '0;
  int          edges = 0;
  int          low_len = 0;
  int          hi_len = 0;
  int          last_gap = 0;
  int          n_frames = 0;
  int          sclk_rises = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_on    = 1'b0;
      prev_ncs  = 1'b1;
      prev_sclk = 1'b0;
      hi_len    = 0;
    end else begin
      if (prev_ncs && !ncs) begin
        cap_on   = 1'b1;
        cap      = '0;
        edges    = 0;
        low_len  = 0;
        last_gap = hi_len;
      end
      if (!ncs) low_len++;
      if (ncs) hi_len = prev_ncs ? hi_len + 1 : 1;
      if (!prev_sclk && sclk) begin
        sclk_rises++;
        if (cap_on) begin
          cap = {cap[14:0], copi};
          edges++;
        end
      end
      if (cap_on && !prev_ncs && ncs) begin
        check("frame_len", 32'(low_len), 32'(LOW_CYC));
        check("frame_edges", 32'(edges), 32'd16);
        if (exp_q.size() > 0) check("frame_bits", 32'(cap), 32'(exp_q.pop_front()));
        else check("frame_unexpected", 32'(cap), 32'hFFFF_FFFF);
        last_cap = cap;
        n_frames++;
        cap_on = 1'b0;
      end
      prev_ncs  = ncs;
      prev_sclk = sclk;
    end
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  // Peripheral-side responder: shifts cur_rsp out on sclk falls 8..15.
  int fall_n = 0;
  initial cipo = 1'b0;
  always @(negedge ncs) begin
    cur_rsp = 8'($urandom);
    fall_n  = 0;
  end
  always @(negedge sclk) begin
    fall_n++;
    if (fall_n >= 8 && fall_n <= 15) cipo = cur_rsp[15 - fall_n];
  end
`endif

  task automatic wait_accept(input int budget);
    int prev;
    prev = n_accept;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_accept != prev) return;
    end
    check("accept_timeout", 32'(n_accept), 32'(prev + 1));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy == 0) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [15:0] f);
    req_valid = 1'b1;
    {req_rw, req_addr, req_data} = f;
    wait_accept(4 * BUSY_CYC);
    req_valid = 1'b0;
    {req_rw, req_addr, req_data} = 16'(~f);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_ncs"},   32'(ncs),       32'd1);
    check({tag, "_sclk"},  32'(sclk),      32'd0);
    check({tag, "_copi"},  32'(copi),      32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  initial begin
    int acc0;
    int frm0;
    int target;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1 check_idle_pins("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write frame.
    send(16'h80A5);
    wait_idle(2 * BUSY_CYC);
    repeat (3) @(negedge clk);
    check("single_cap", 32'(last_cap), 32'h80A5);
    check("single_frames", 32'(n_frames), 32'd1);

    // Back-to-back with valid held.
    req_valid = 1'b1;
    {req_rw, req_addr, req_data} = 16'h8011;
    wait_accept(4 * BUSY_CYC);
    {req_rw, req_addr, req_data} = 16'h843C;
    wait_accept(4 * BUSY_CYC);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_gap", 32'(last_gap), 32'(CD + 1));
    wait_idle(2 * BUSY_CYC);
    repeat (3) @(negedge clk);
    check("b2b_cap", 32'(last_cap), 32'h843C);
    check("b2b_frames", 32'(n_frames), 32'd3);

    // Valid pulsed while busy must be ignored.
    send(16'h8022);
    repeat (10 * CD) @(negedge clk);
    req_valid = 1'b1;
    {req_rw, req_addr, req_data} = {1'b1, 7'h01, 8'hFF};
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_idle(2 * BUSY_CYC);
    repeat (3 * CD) @(negedge clk);
    check("busy_cap", 32'(last_cap), 32'h8022);
    check("busy_frames", 32'(n_frames), 32'd4);

    // Reset after 7 sclk rising edges aborts the frame.
    frm0 = n_frames;
    send(16'h8055);
    target = sclk_rises + 7;
    for (int i = 0; i < 4 * BUSY_CYC && sclk_rises < target; i++) @(negedge clk);
    check("abort_reach", 32'(sclk_rises), 32'(target));
    check("abort_ncs_pre", 32'(ncs), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_pins("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_frames", 32'(n_frames), 32'(frm0));
    send(16'h8077);
    wait_idle(2 * BUSY_CYC);
    repeat (3) @(negedge clk);
    check("post_abort_cap", 32'(last_cap), 32'h8077);

    // Randomised traffic.
    acc0 = n_accept;
    frm0 = n_frames;
    repeat (3000) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_rw    = 1'($urandom);
      req_addr  = 7'($urandom);
      req_data  = 8'($urandom);
    end
    req_valid = 1'b0;
    wait_idle(2 * BUSY_CYC);
    repeat (3) @(negedge clk);
    check("rand_frames", 32'(n_frames - frm0), 32'(n_accept - acc0));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
